down_counter: RTL and testbench

//   Loadable down-counter/timer; counts the opposite direction to the up-counter block.

---
 rtl/counter_pkg.sv | 10 +
 rtl/enable_prescaler.sv | 30 +++
 rtl/down_counter.sv | 92 +++++++++
 tb/tb_down_counter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared counter state encodings
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } counter_state_e;

endpackage

// File: rtl/enable_prescaler.sv
// rtl/enable_prescaler.sv - emits one tick per PRESCALE enabled cycles
module enable_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Counts enabled cycles only; a load restarts the division phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable one-shot/periodic down-counter
// Optional macro DOWN_COUNTER_PRESCALE_EN divides enable by PRESCALE.
module down_counter
  import counter_pkg::*;
#(
  parameter int COUNTER_SIZE = 4,
  parameter int PRESCALE     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [COUNTER_SIZE-1:0] load_value,
  input  logic                    auto_reload,
  output logic [COUNTER_SIZE-1:0] counter_output,
  output logic                    terminal_count,
  output logic                    running
);

  counter_state_e          state, state_next;
  logic [COUNTER_SIZE-1:0] count_next;
  logic [COUNTER_SIZE-1:0] reload_reg, reload_next;
  logic                    tc_next;
  logic                    tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
  enable_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .clear  (load),
    .tick   (tick)
  );
`else
  assign tick = enable;
  // PRESCALE has no effect without prescaling; kept so both builds share one parameter list.
  if (PRESCALE < 1) begin : g_prescale_unused
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      counter_output <= '0;
      reload_reg     <= '0;
    end else begin
      state          <= state_next;
      counter_output <= count_next;
      reload_reg     <= reload_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = counter_output;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    if (load) begin
      count_next  = load_value;
      reload_next = load_value;
      state_next  = (load_value != '0) ? ST_RUN : ST_DONE;
    end else if (state == ST_RUN && tick) begin
      if (counter_output > COUNTER_SIZE'(1)) begin
        count_next = counter_output - COUNTER_SIZE'(1);
      end else if (counter_output == COUNTER_SIZE'(1)) begin
        count_next = '0;
        tc_next    = 1'b1;
        state_next = auto_reload ? ST_RUN : ST_DONE;
      end else if (auto_reload) begin
        // Periodic mode spends one tick at zero before reloading: period N+1.
        count_next = reload_reg;
      end else begin
        state_next = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      terminal_count <= 1'b0;
    end else begin
      terminal_count <= tc_next;
    end
  end

  always_comb begin
    running = (state == ST_RUN);
  end

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - directed and random checks of down_counter against a behavioural model
module tb_down_counter;

  localparam int W = 4;
`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic         auto_reload;
  logic [W-1:0] counter_output;
  logic         terminal_count;
  logic         running;

  int errors = 0;
  int checks = 0;

  // Model: the timer is "armed" after a nonzero load until a one-shot expires.
  int m_count, m_reload, m_enabled_cycles;
  bit m_armed, m_tc;

  down_counter #(
    .COUNTER_SIZE(W),
    .PRESCALE    (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .load          (load),
    .load_value    (load_value),
    .auto_reload   (auto_reload),
    .counter_output(counter_output),
    .terminal_count(terminal_count),
    .running       (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_reload = 0;
    m_enabled_cycles = 0;
    m_armed = 0;
    m_tc = 0;
  endtask

  task automatic model_clock(input bit en, input bit ld, input int lv, input bit ar);
    bit decrement_due;
    m_tc = 0;
    if (ld) begin
      m_count = lv;
      m_reload = lv;
      m_enabled_cycles = 0;
      m_armed = (lv != 0);
    end else begin
      decrement_due = 0;
      if (en) begin
        m_enabled_cycles = m_enabled_cycles + 1;
        if (m_enabled_cycles % PS == 0) decrement_due = 1;
      end
      if (m_armed && decrement_due) begin
        if (m_count == 0) begin
          if (ar) m_count = m_reload;
          else m_armed = 0;
        end else begin
          m_count = m_count - 1;
          if (m_count == 0) begin
            m_tc = 1;
            if (!ar) m_armed = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".count"}, counter_output, m_count);
    chk({tag, ".tc"}, terminal_count, m_tc);
    chk({tag, ".running"}, running, m_armed);
  endtask

  task automatic step(input string tag, input bit en, input bit ld, input int lv, input bit ar);
    @(negedge clk);
    enable = en;
    load = ld;
    load_value = W'(lv);
    auto_reload = ar;
    @(posedge clk);
    model_clock(en, ld, lv, ar);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    load = 1'b0;
    load_value = '0;
    auto_reload = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.count", counter_output, 0);
    chk("reset.tc", terminal_count, 0);
    chk("reset.running", running, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) step("idle_enable", 1, 0, 0, 0);

    step("oneshot_load", 0, 1, 5, 0);
    for (int i = 0; i < 5 * PS + 4; i++) step("oneshot", 1, 0, 0, 0);
    chk("oneshot.final", counter_output, 0);

    step("periodic_load", 0, 1, 3, 1);
    for (int i = 0; i < 12 * PS; i++) step("periodic", 1, 0, 0, 1);

    step("toggle_load", 0, 1, 9, 0);
    for (int i = 0; i < 10 * PS; i++) step("toggle", bit'(i % 2 == 0), 0, 0, 0);
    step("reload_over_enable", 1, 1, 7, 0);
    chk("reload_over_enable.value", counter_output, 7);
    step("after_reload", 1, 0, 0, 0);
    async_reset("reset_mid_count");

    step("zero_load", 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("zero_hold", 1, 0, 0, 0);

    step("max_load", 0, 1, 15, 0);
    for (int i = 0; i < 17 * PS; i++) step("max_count", 1, 0, 0, 0);

    step("drop_ar_load", 0, 1, 2, 1);
    for (int i = 0; i < 2 * PS; i++) step("drop_ar_count", 1, 0, 0, 1);
    for (int i = 0; i < 2 * PS; i++) step("drop_ar_done", 1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rand_reset");
      end else begin
        step("random", bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 11) == 0),
             int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
